// File: rtl/rv_mem_pkg.sv
// Shared constants and access-legality helpers for the RV32I load/store stage.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANES = 4;

    function automatic logic load_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // Only meaningful for legal codes: bits [1:0] encode the access size.
    function automatic logic access_misaligned(input logic [2:0] f3,
                                               input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        if (f3[1:0] == 2'b01) mis = lane[0];
        if (f3[1:0] == 2'b10) mis = (lane != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Lane selection and sign/zero extension of a raw memory word for RV32I loads.
module load_extend
    import rv_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            F3_W:    data_o = word_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_stage.sv
// RV32I load/store stage: word-organised memory with byte-lane stores,
// extended combinational loads, fault detection and a sticky error flag.
module data_memory_stage
    import rv_mem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        err_clear,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        err_sticky
);

    logic [31:0]       mem_q [DEPTH];
    logic              err_q, err_d;

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              ld_legal, st_legal, size_mis;
    logic              ld_mis, st_mis, ld_ill, st_ill;
    logic              ld_ok, wr_en;
    logic [LANES-1:0]  byte_en;
    logic [31:0]       wr_word;
    logic [31:0]       raw_word, ext_word;

    // Addresses wrap modulo DEPTH*4; the upper bits are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, addr[31:ADDR_W+2]};

    assign word_idx = addr[ADDR_W+1:2];
    assign lane     = addr[1:0];
    assign raw_word = mem_q[word_idx];

    assign ld_legal = load_legal(funct3);
    assign st_legal = store_legal(funct3);
    assign size_mis = access_misaligned(funct3, lane);

    assign ld_ill = mem_read  && !ld_legal;
    assign st_ill = mem_write && !st_legal;
    assign ld_mis = mem_read  && ld_legal && size_mis;
    assign st_mis = mem_write && st_legal && size_mis;

    assign misaligned = ld_mis | st_mis;
    assign illegal    = ld_ill | st_ill;

    assign ld_ok = mem_read  && ld_legal && !size_mis;
    assign wr_en = mem_write && st_legal && !size_mis;

    load_extend u_load_extend (
        .word_i   (raw_word),
        .lane_i   (lane),
        .funct3_i (funct3),
        .data_o   (ext_word)
    );

    assign read_data = ld_ok ? ext_word : 32'd0;

    // Store data is replicated across lanes so byte_en alone picks what lands.
    always_comb begin
        byte_en = '0;
        wr_word = write_data;
        case (funct3[1:0])
            2'b00: begin
                byte_en = LANES'(1) << lane;
                wr_word = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{write_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = write_data;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // A fault on the same edge beats err_clear.
    always_comb begin
        err_d = err_q;
        if (misaligned || illegal) begin
            err_d = 1'b1;
        end else if (err_clear) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_sticky = err_q;

endmodule
